pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline stage register for the five-stage core and later deeper pipes.
//  Carries a control field and a data payload between two stages with valid/ready handshake,
//  synchronous flush (bubble insertion) and an optional 2-entry skid buffer so in_ready is registered.
//  Replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
// PARAMETERS
//  CTRL_WIDTH  10  width of control field (e.g. M+WB control bits); zeroed on bubbles
//  DATA_WIDTH  200 width of payload (PC, ALU result, rs2 data, rd addr, ...) concatenated
//  SKID        1   1: 2-entry skid, registered in_ready; 0: single entry, combinational in_ready
//  CNT_WIDTH   16  width of stall performance counter
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  flush      in   1           synchronous flush: kill all held and incoming entries
//  in_valid   in   1           upstream entry valid
//  in_ready   out  1           stage can accept (transfer when in_valid & in_ready)
//  in_ctrl    in   CTRL_WIDTH  upstream control field
//  in_data    in   DATA_WIDTH  upstream payload
//  out_valid  out  1           entry presented downstream
//  out_ready  in   1           downstream accepts (transfer when out_valid & out_ready)
//  out_ctrl   out  CTRL_WIDTH  control field; forced 0 whenever out_valid=0
//  out_data   out  DATA_WIDTH  payload; don't-care when out_valid=0
//  stall_cnt  out  CNT_WIDTH   saturating count of cycles with out_valid & !out_ready
//  stat_clr   in   1           synchronous clear of stall_cnt
// BEHAVIOUR
//  Reset (rst_n=0, async): state=EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid regs=0,
//   stall_cnt=0; in_ready=1 (EMPTY decode); upstream must hold in_valid=0 during reset.
//  Latency: accepted entry appears on out_* the next cycle (1-cycle), FIFO order, no loss/dup.
//  States (SKID=1): EMPTY (no entry), ONE (main reg holds entry), FULL (main+skid hold).
//   EMPTY: in_valid -> ONE, main<=in.
//   ONE: in_valid&out_ready -> ONE, main<=in; in_valid&!out_ready -> FULL, skid<=in;
//        !in_valid&out_ready -> EMPTY; else hold.
//   FULL: out_ready -> ONE, main<=skid; else hold. in_ready=0 in FULL only, from state reg.
//  SKID=0: states EMPTY/ONE only; in_ready = !out_valid | out_ready (combinational);
//   simultaneous pop+push keeps ONE with main<=in.
//  Handshake: out_valid/out_ctrl/out_data stable while out_valid & !out_ready (no retraction).
//  flush=1: highest priority over push/pop; next state EMPTY, out_valid=0, out_ctrl=0;
//   entry offered same cycle is dropped even if in_ready=1; in_ready=1 the following cycle.
//  stall_cnt: +1 each cycle out_valid&!out_ready; saturates at all-ones (no wrap);
//   stat_clr has priority over increment; not affected by flush.
//  Reset mid-transfer: all held entries lost, no partial outputs; resumes from EMPTY.
//  No arithmetic on payload; widths passed through bit-exact.
// STRUCTURE
//  pipe_pkg: typedef enum logic[1:0] {ST_EMPTY, ST_ONE, ST_FULL} pipe_state_t;
//   shared CTRL width constants (M_CTRL_BITS, WB_CTRL_BITS) used by all stage instances.
//  One sub-module: sat_counter (CNT_WIDTH, inc, clr, saturating) for stall_cnt.
//  Main/skid registers and FSM in this module; generate on SKID selects in_ready path.
// TESTING
//  T1 reset: rst_n=0 mid-stream with FULL -> out_valid=0, out_ctrl=0, stall_cnt=0 immediately.
//  T2 streaming: in_valid=1, out_ready=1, data 1..100 -> out_data 1..100 in order, one per cycle
//   after 1-cycle latency, in_ready stays 1.
//  T3 backpressure SKID=1: push A,B with out_ready=0 -> in_ready=0 after B; raise out_ready ->
//   A then B delivered, no loss; stall_cnt counts held cycles exactly.
//  T4 flush in FULL with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, C never appears.
//  T5 stall_cnt CNT_WIDTH=4: 20 stall cycles -> reads 15; stat_clr with stall -> 0 next cycle.
//  T6 SKID=0 random valid/ready 10k cycles -> scoreboard match, in_ready == !out_valid|out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: types and width constants shared by every pipeline stage instance.
//   pipe_state_t : occupancy of an elastic stage (empty / main only / main+skid)
//   M_CTRL_BITS, WB_CTRL_BITS : control bits carried into MEM and WB
package pipe_pkg;

  localparam int unsigned M_CTRL_BITS  = 4;
  localparam int unsigned WB_CTRL_BITS = 6;
  localparam int unsigned CTRL_BITS    = M_CTRL_BITS + WB_CTRL_BITS;
  localparam int unsigned PAYLOAD_BITS = 200;
  localparam int unsigned STALL_BITS   = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clear wins over increment.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear
//   inc_i      : count enable
//   cnt_o      : current count (registered)
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: generic valid/ready pipeline register between two core stages.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous kill of held and incoming entries
//   in_valid/in_ready   : upstream handshake (in_ready registered when SKID=1)
//   in_ctrl/in_data     : upstream control field and payload
//   out_valid/out_ready : downstream handshake
//   out_ctrl/out_data   : held entry; out_ctrl is zero on bubbles
//   stall_cnt/stat_clr  : saturating count of downstream-stalled cycles, clear
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = CTRL_BITS,
  parameter int unsigned DATA_WIDTH = PAYLOAD_BITS,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_WIDTH  = STALL_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  input  logic                  stat_clr
);

  localparam logic SKID_EN = 1'(SKID != 0);

  pipe_state_t           state_q, state_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  // Occupancy FSM and entry movement; main_ctrl is zeroed whenever the stage
  // empties so out_ctrl reads 0 on every bubble straight from the register.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_valid && SKID_EN) begin
            // Downstream stalled: park the new entry behind the held one.
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (!in_valid && out_ready) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Upstream ready: state decode with skid, else pass-through of out_ready.
  if (SKID != 0) begin : g_skid
    assign in_ready = (state_q != ST_FULL);
  end else begin : g_noskid
    assign in_ready = (state_q == ST_EMPTY) | out_ready;
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (stat_clr),
    .inc_i (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: u0 has the skid buffer and a 4-bit stall counter,
// u1 is the single-entry variant. A queue per instance models the stage as a
// bounded FIFO; monitors pop and compare whenever an output transfer happens.
module tb_pipe_stage_elastic;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 200;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [CW-1:0] in_ctrl   [2];
  logic [DW-1:0] in_data   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [DW-1:0] out_data  [2];
  logic          stat_clr  [2];
  logic [3:0]    stall_a;
  logic [15:0]   stall_b;

  // Requested inputs for the next step.
  logic          d_valid [2];
  logic          d_ready [2];
  logic          d_flush [2];
  logic          d_clr   [2];
  logic [CW-1:0] d_ctrl  [2];
  logic [DW-1:0] d_data  [2];

  item_t       sbq [2][$];
  int unsigned stall_m [2];
  int unsigned stall_max [2];
  int unsigned cap [2];
  int          n_vec;
  int          n_err;

  pipe_stage_elastic #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1), .CNT_WIDTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_ctrl(in_ctrl[0]), .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_ctrl(out_ctrl[0]), .out_data(out_data[0]), .stall_cnt(stall_a), .stat_clr(stat_clr[0]));

  pipe_stage_elastic #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(0), .CNT_WIDTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_ctrl(in_ctrl[1]), .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_ctrl(out_ctrl[1]), .out_data(out_data[1]), .stall_cnt(stall_b), .stat_clr(stat_clr[1]));

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] get_stall(input int k);
    return (k == 0) ? DW'(stall_a) : DW'(stall_b);
  endfunction

  // Directed input for u0; u1 idles with out_ready high.
  task automatic set_a(input logic v, input logic r, input logic f, input logic c,
                       input logic [DW-1:0] dat);
    d_valid[0] = v; d_ready[0] = r; d_flush[0] = f; d_clr[0] = c;
    d_data[0]  = dat; d_ctrl[0] = CW'(dat) ^ 10'h2A5;
    d_valid[1] = 1'b0; d_ready[1] = 1'b1; d_flush[1] = 1'b0; d_clr[1] = 1'b0;
    d_data[1]  = '0; d_ctrl[1] = '0;
  endtask

  task automatic rand_inputs(input int k);
    logic [223:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    d_valid[k] = 1'($urandom_range(0, 1));
    d_ready[k] = 1'($urandom_range(0, 3) != 0);
    d_flush[k] = 1'($urandom_range(0, 31) == 0);
    d_clr[k]   = 1'($urandom_range(0, 63) == 0);
    d_data[k]  = w[DW-1:0];
    d_ctrl[k]  = CW'($urandom());
  endtask

  // One clock of stimulus: check occupancy-derived outputs, apply inputs,
  // then advance the FIFO model and the stall-counter model.
  task automatic step();
    int    held [2];
    logic  exp_rdy;
    item_t it;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      held[k] = sbq[k].size();
      chk($sformatf("u%0d out_valid", k), DW'(out_valid[k]), DW'(held[k] > 0));
      chk($sformatf("u%0d stall_cnt", k), get_stall(k), DW'(stall_m[k]));
    end
    for (int k = 0; k < 2; k++) begin
      flush[k] = d_flush[k]; in_valid[k] = d_valid[k]; out_ready[k] = d_ready[k];
      stat_clr[k] = d_clr[k]; in_ctrl[k] = d_ctrl[k]; in_data[k] = d_data[k];
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_rdy = (held[k] < int'(cap[k])) || (cap[k] == 1 && d_ready[k]);
      chk($sformatf("u%0d in_ready", k), DW'(in_ready[k]), DW'(exp_rdy));
      if (!d_flush[k] && d_valid[k] && exp_rdy) begin
        it.c = d_ctrl[k];
        it.d = d_data[k];
        sbq[k].push_back(it);
      end
      if (d_clr[k]) stall_m[k] = 0;
      else if (held[k] > 0 && !d_ready[k] && stall_m[k] < stall_max[k]) stall_m[k]++;
    end
    #2;
    for (int k = 0; k < 2; k++) if (d_flush[k]) sbq[k].delete();
  endtask

  // Output monitor: pops the expected entry on every downstream transfer.
  task automatic monitor(input int k);
    item_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (!out_valid[k]) begin
          chk($sformatf("u%0d bubble_ctrl", k), DW'(out_ctrl[k]), '0);
        end else if (out_ready[k]) begin
          if (sbq[k].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL u%0d unexpected_output actual=%0h required=none", k, out_data[k]);
          end else begin
            e = sbq[k].pop_front();
            chk($sformatf("u%0d out_data", k), out_data[k], e.d);
            chk($sformatf("u%0d out_ctrl", k), DW'(out_ctrl[k]), DW'(e.c));
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0; stat_clr[k] = 1'b0;
      in_ctrl[k] = '0; in_data[k] = '0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    cap[0] = 2; cap[1] = 1;
    stall_max[0] = 15; stall_max[1] = 65535;
    stall_m[0] = 0; stall_m[1] = 0;
    rst_n = 1'b0;
    clear_inputs();
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d rst out_valid", k), DW'(out_valid[k]), '0);
      chk($sformatf("u%0d rst in_ready", k), DW'(in_ready[k]), DW'(1));
      chk($sformatf("u%0d rst out_ctrl", k), DW'(out_ctrl[k]), '0);
      chk($sformatf("u%0d rst out_data", k), out_data[k], '0);
      chk($sformatf("u%0d rst stall", k), get_stall(k), '0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming 1..100 at full rate.
    for (int i = 1; i <= 100; i++) begin
      set_a(1'b1, 1'b1, 1'b0, 1'b0, DW'(i));
      step();
    end
    set_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step();
    step();

    // Backpressure into the skid, then release.
    set_a(1'b0, 1'b1, 1'b0, 1'b1, '0);      step();
    set_a(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'hA0A)); step();
    set_a(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'hB0B)); step();
    set_a(1'b0, 1'b0, 1'b0, 1'b0, '0);      step();
    chk("full in_ready", DW'(in_ready[0]), '0);
    set_a(1'b0, 1'b1, 1'b0, 1'b0, '0);      step();
    step();
    after_edge();
    chk("bp stall_cnt", DW'(stall_a), DW'(2));
    chk("bp drained", DW'(out_valid[0]), '0);

    // Flush while full with a new entry offered.
    set_a(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h1111)); step();
    set_a(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h2222)); step();
    set_a(1'b1, 1'b0, 1'b1, 1'b0, DW'(16'hCCCC)); step();
    after_edge();
    chk("flush out_valid", DW'(out_valid[0]), '0);
    chk("flush out_ctrl", DW'(out_ctrl[0]), '0);
    chk("flush in_ready", DW'(in_ready[0]), DW'(1));
    set_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) step();

    // Stall counter saturation and clear.
    set_a(1'b0, 1'b0, 1'b0, 1'b1, '0);      step();
    set_a(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h5A5)); step();
    set_a(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (20) step();
    after_edge();
    chk("sat stall_cnt", DW'(stall_a), DW'(15));
    set_a(1'b0, 1'b0, 1'b0, 1'b1, '0);      step();
    after_edge();
    chk("clr stall_cnt", DW'(stall_a), '0);
    set_a(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) step();

    // Asynchronous reset while full.
    set_a(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h7777)); step();
    set_a(1'b1, 1'b0, 1'b0, 1'b0, DW'(16'h8888)); step();
    set_a(1'b0, 1'b0, 1'b0, 1'b0, '0);      step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", DW'(out_valid[0]), '0);
    chk("midrst out_ctrl", DW'(out_ctrl[0]), '0);
    chk("midrst stall_cnt", DW'(stall_a), '0);
    chk("midrst in_ready", DW'(in_ready[0]), DW'(1));
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      sbq[k].delete();
      stall_m[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic on both variants.
    for (int i = 0; i < 10000; i++) begin
      rand_inputs(0);
      rand_inputs(1);
      step();
    end
    for (int k = 0; k < 2; k++) begin
      d_valid[k] = 1'b0; d_ready[k] = 1'b1; d_flush[k] = 1'b0; d_clr[k] = 1'b0;
    end
    repeat (4) step();
    after_edge();
    for (int k = 0; k < 2; k++)
      chk($sformatf("u%0d drain", k), DW'(sbq[k].size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
